// File: rtl/mandel_iter_unit.sv
// mandel_iter_unit: single-pixel escape-time engine (Mandelbrot / Julia).
// Iterates z <- z^2 + c in signed Q(WIDTH-FRAC).FRAC fixed point, two cycles
// per iteration (MUL then UPD), and returns count / escaped / tag over a
// valid/ready handshake. Only one pixel is ever in flight.
//
// Build option: define MANDEL_BULB_SKIP_EN to short-circuit Mandelbrot
// coordinates that fall inside a conservative box of the main cardioid or the
// period-2 bulb. Those pixels report MAX_ITER, not escaped, one cycle after
// accept. With the macro undefined every pixel iterates; results match, only
// the latency differs.
module mandel_iter_unit #(
  parameter int WIDTH    = 27,
  parameter int FRAC     = 23,
  parameter int CNT_W    = 10,
  parameter int MAX_ITER = 1000,
  parameter int TAG_W    = 19
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic signed [WIDTH-1:0] jre,
  input  logic signed [WIDTH-1:0] jim,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_escaped,
  output logic [TAG_W-1:0]        out_tag
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_UPD  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  // Escape thresholds: |component| >= 2 before squaring, |z|^2 >= 4 after.
  localparam logic signed [WIDTH-1:0] K_TWO     = WIDTH'(longint'(2) <<< FRAC);
  localparam logic signed [WIDTH-1:0] K_NEG_TWO = -K_TWO;
  localparam logic signed [WIDTH:0]   K_FOUR    = (WIDTH+1)'(longint'(4) <<< FRAC);
  localparam logic [CNT_W-1:0]        K_CAP     = CNT_W'(MAX_ITER);

  state_t                  r_state;
  logic signed [WIDTH-1:0] r_zre;
  logic signed [WIDTH-1:0] r_zim;
  logic signed [WIDTH-1:0] r_cre;
  logic signed [WIDTH-1:0] r_cim;
  logic signed [WIDTH-1:0] r_sre;
  logic signed [WIDTH-1:0] r_sim;
  logic signed [WIDTH-1:0] r_x;
  logic [CNT_W-1:0]        r_count;
  logic                    r_escaped;
  logic [TAG_W-1:0]        r_tag;

  logic signed [WIDTH-1:0] w_sre;
  logic signed [WIDTH-1:0] w_sim;
  logic signed [WIDTH-1:0] w_x;
  logic signed [WIDTH:0]   w_sum;
  logic signed [WIDTH-1:0] w_zre_next;
  logic signed [WIDTH-1:0] w_zim_next;
  logic                    w_z_out;
  logic                    w_sum_out;
  logic                    w_at_cap;
  logic                    w_in_bulb;

  // Full-precision signed product, keeping the WIDTH bits aligned to FRAC.
  // Callers guarantee |a|,|b| < 2 so the dropped high bits are pure sign.
  function automatic logic signed [WIDTH-1:0] fx_mul(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [2*WIDTH-1:0] p;
    p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    return p[WIDTH+FRAC-1:FRAC];
  endfunction

  assign w_sre = fx_mul(r_zre, r_zre);
  assign w_sim = fx_mul(r_zim, r_zim);
  assign w_x   = fx_mul(r_zre, r_zim);

  // One extra bit so sre + sim (each < 4) cannot wrap before the >= 4 test.
  assign w_sum      = {r_sre[WIDTH-1], r_sre} + {r_sim[WIDTH-1], r_sim};
  assign w_sum_out  = (w_sum >= K_FOUR);
  assign w_zre_next = r_sre - r_sim + r_cre;
  assign w_zim_next = (r_x <<< 1) + r_cim;

  // Guards the multipliers: any component at or beyond +/-2 has escaped.
  assign w_z_out = (r_zre >= K_TWO) || (r_zre <= K_NEG_TWO) ||
                   (r_zim >= K_TWO) || (r_zim <= K_NEG_TWO);

  assign w_at_cap = (r_count == K_CAP);

`ifdef MANDEL_BULB_SKIP_EN
  // Box corners scaled to fixed point at elaboration. Each bound is rounded
  // toward the box interior so the boxes never grow past the real limits.
  localparam longint ONE_L = longint'(1) <<< FRAC;
  localparam logic signed [WIDTH-1:0] K_ZERO        = '0;
  localparam logic signed [WIDTH-1:0] K_MAIN_RE_LO  = WIDTH'(-(ONE_L / 2));
  localparam logic signed [WIDTH-1:0] K_MAIN_IM_HI  = WIDTH'((ONE_L * 4) / 10);
  localparam logic signed [WIDTH-1:0] K_MAIN_IM_LO  = -K_MAIN_IM_HI;
  localparam logic signed [WIDTH-1:0] K_P2_RE_LO    = WIDTH'(-((ONE_L * 117) / 100));
  localparam logic signed [WIDTH-1:0] K_P2_RE_HI    = WIDTH'(-((ONE_L * 83 + 99) / 100));
  localparam logic signed [WIDTH-1:0] K_P2_IM_HI    = WIDTH'((ONE_L * 17) / 100);
  localparam logic signed [WIDTH-1:0] K_P2_IM_LO    = -K_P2_IM_HI;

  logic w_in_main;
  logic w_in_p2;

  assign w_in_main = (in_re > K_MAIN_RE_LO) && (in_re < K_ZERO) &&
                     (in_im > K_MAIN_IM_LO) && (in_im < K_MAIN_IM_HI);
  assign w_in_p2   = (in_re > K_P2_RE_LO) && (in_re < K_P2_RE_HI) &&
                     (in_im > K_P2_IM_LO) && (in_im < K_P2_IM_HI);
  // Julia pixels never skip: the boxes only describe the Mandelbrot set.
  assign w_in_bulb = !mode && (w_in_main || w_in_p2);
`else
  assign w_in_bulb = 1'b0;
`endif

  // Control FSM and datapath registers; all outputs come straight off registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_zre     <= '0;
      r_zim     <= '0;
      r_cre     <= '0;
      r_cim     <= '0;
      r_sre     <= '0;
      r_sim     <= '0;
      r_x       <= '0;
      r_count   <= '0;
      r_escaped <= 1'b0;
      r_tag     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (mode) begin
              r_zre <= in_re;
              r_zim <= in_im;
              r_cre <= jre;
              r_cim <= jim;
            end else begin
              r_zre <= '0;
              r_zim <= '0;
              r_cre <= in_re;
              r_cim <= in_im;
            end
            r_tag     <= in_tag;
            r_escaped <= 1'b0;
            if (w_in_bulb) begin
              r_count <= K_CAP;
              r_state <= S_OUT;
            end else begin
              r_count <= '0;
              r_state <= S_MUL;
            end
          end
        end
        S_MUL: begin
          if (w_z_out) begin
            r_escaped <= 1'b1;
            r_state   <= S_OUT;
          end else begin
            r_sre   <= w_sre;
            r_sim   <= w_sim;
            r_x     <= w_x;
            r_state <= S_UPD;
          end
        end
        S_UPD: begin
          if (w_sum_out) begin
            r_escaped <= 1'b1;
            r_state   <= S_OUT;
          end else if (w_at_cap) begin
            r_escaped <= 1'b0;
            r_state   <= S_OUT;
          end else begin
            r_zre   <= w_zre_next;
            r_zim   <= w_zim_next;
            r_count <= r_count + 1'b1;
            r_state <= S_MUL;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // IDLE is the only state that takes a new pixel, so accept and consume
  // can never coincide.
  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_OUT);
  assign out_count   = r_count;
  assign out_escaped = r_escaped;
  assign out_tag     = r_tag;

endmodule

// File: tb/tb_mandel_iter_unit.sv
// Directed bench for mandel_iter_unit (WIDTH 27, FRAC 23, MAX_ITER 16).
module tb_mandel_iter_unit;

  localparam int WIDTH    = 27;
  localparam int FRAC     = 23;
  localparam int CNT_W    = 10;
  localparam int MAX_ITER = 16;
  localparam int TAG_W    = 19;
  localparam int BUDGET   = 200;

  // Q4.23 constants
  localparam logic signed [WIDTH-1:0] FX_0    = 27'sd0;
  localparam logic signed [WIDTH-1:0] FX_1    = 27'sd8388608;
  localparam logic signed [WIDTH-1:0] FX_1P5  = 27'sd12582912;
  localparam logic signed [WIDTH-1:0] FX_2    = 27'sd16777216;
  localparam logic signed [WIDTH-1:0] FX_3    = 27'sd25165824;
  localparam logic signed [WIDTH-1:0] FX_M1   = -27'sd8388608;
  localparam logic signed [WIDTH-1:0] FX_M2   = -27'sd16777216;
  localparam logic signed [WIDTH-1:0] FX_MQ   = -27'sd2097152;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    mode = 1'b0;
  logic signed [WIDTH-1:0] jre = '0;
  logic signed [WIDTH-1:0] jim = '0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_re = '0;
  logic signed [WIDTH-1:0] in_im = '0;
  logic [TAG_W-1:0]        in_tag = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [CNT_W-1:0]        out_count;
  logic                    out_escaped;
  logic [TAG_W-1:0]        out_tag;

  int n_checks = 0;
  int n_fail   = 0;

  mandel_iter_unit #(
    .WIDTH(WIDTH), .FRAC(FRAC), .CNT_W(CNT_W), .MAX_ITER(MAX_ITER), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .jre(jre), .jim(jim),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_escaped(out_escaped), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offer one pixel, measure latency, check the result, hold, then consume.
  // When scramble is set, mode/jre/jim are disturbed while the pixel runs.
  task automatic run_pixel(input string name, input logic m,
                           input logic signed [WIDTH-1:0] re, input logic signed [WIDTH-1:0] im,
                           input logic signed [WIDTH-1:0] jr, input logic signed [WIDTH-1:0] ji,
                           input logic [TAG_W-1:0] tag, input int exp_cnt,
                           input logic exp_esc, input int exp_cyc,
                           input int hold, input logic scramble);
    int  cyc;
    logic seen;
    logic [CNT_W-1:0] cnt0;
    logic [TAG_W-1:0] tag0;
    logic esc0;
    @(negedge clk);
    mode = m; in_re = re; in_im = im; jre = jr; jim = ji; in_tag = tag;
    in_valid = 1'b1;
    chk({name, " in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < BUDGET) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_re = '0; in_im = '0; in_tag = '0;
      if (scramble) begin
        mode = ~m; jre = 27'h5a5a5a5; jim = 27'h3ffffff;
      end
      cyc++;
      seen = out_valid;
    end
    chk({name, " seen"}, 64'(seen), 64'd1);
    chk({name, " latency"}, 64'(cyc), 64'(exp_cyc));
    chk({name, " count"}, 64'(out_count), 64'(exp_cnt));
    chk({name, " escaped"}, 64'(out_escaped), 64'(exp_esc));
    chk({name, " tag"}, 64'(out_tag), 64'(tag));
    cnt0 = out_count; esc0 = out_escaped; tag0 = out_tag;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, " hold valid"}, 64'(out_valid), 64'd1);
      chk({name, " hold ready"}, 64'(in_ready), 64'd0);
      chk({name, " hold fields"}, 64'({out_count, out_escaped, out_tag}),
          64'({cnt0, esc0, tag0}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, " consumed"}, 64'(out_valid), 64'd0);
    chk({name, " idle"}, 64'(in_ready), 64'd1);
  endtask

  int cap_bulb_cyc;
  int m1_cyc;
  int rc;

  initial begin
`ifdef MANDEL_BULB_SKIP_EN
    cap_bulb_cyc = 1;
    m1_cyc       = 1;
`else
    cap_bulb_cyc = 2 * MAX_ITER + 3;
    m1_cyc       = 2 * MAX_ITER + 3;
`endif
    // Reset state
    #1;
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_count", 64'(out_count), 64'd0);
    chk("rst out_escaped", 64'(out_escaped), 64'd0);
    chk("rst out_tag", 64'(out_tag), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // c = 2: escapes in MUL at count 1 -> cycle 4
    run_pixel("m c=2", 1'b0, FX_2, FX_0, FX_0, FX_0, 19'h00011, 1, 1'b1, 4, 0, 1'b0);
    // c = 1: count 2, tag returned unchanged
    run_pixel("m c=1", 1'b0, FX_1, FX_0, FX_0, FX_0, 19'h01234, 2, 1'b1, 6, 0, 1'b0);
    // c = -2 and c = 2i: negative / imaginary escape paths
    run_pixel("m c=-2", 1'b0, FX_M2, FX_0, FX_0, FX_0, 19'h7ffff, 1, 1'b1, 4, 0, 1'b0);
    run_pixel("m c=2i", 1'b0, FX_0, FX_2, FX_0, FX_0, 19'h00abc, 1, 1'b1, 4, 0, 1'b0);
    // c = 1.5+1.5i: |z|^2 = 4.5 at count 1 -> UPD escape, cycle 2k+3 = 5
    run_pixel("m c=1.5+1.5i", 1'b0, FX_1P5, FX_1P5, FX_0, FX_0, 19'h00005, 1, 1'b1, 5, 0, 1'b0);
    // c = -1: period-2 orbit, capped
    run_pixel("m c=-1", 1'b0, FX_M1, FX_0, FX_0, FX_0, 19'h00100, MAX_ITER, 1'b0, m1_cyc, 0, 1'b0);
    // c = -0.25: inside main cardioid, capped
    run_pixel("m c=-0.25", 1'b0, FX_MQ, FX_0, FX_0, FX_0, 19'h00200, MAX_ITER, 1'b0, cap_bulb_cyc, 0, 1'b0);
    // Julia c=0, z0=3: escapes at once, then held 10 cycles
    run_pixel("j z0=3", 1'b1, FX_3, FX_0, FX_0, FX_0, 19'h00300, 0, 1'b1, 2, 10, 1'b0);
    // Julia c=1, z0=0, with mode/jre/jim scrambled while busy
    run_pixel("j c=1", 1'b1, FX_0, FX_0, FX_1, FX_0, 19'h00400, 2, 1'b1, 6, 0, 1'b1);
    mode = 1'b0; jre = '0; jim = '0;

    // Asynchronous reset mid-iteration (c = 1.5+1.5i is busy for 5 cycles,
    // c = -1 long enough when not skipped; use a slow Julia pixel instead)
    @(negedge clk);
    mode = 1'b1; jre = FX_M1; jim = FX_0; in_re = FX_0; in_im = FX_0;
    in_tag = 19'h00777; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre-reset busy", 64'(in_ready), 64'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("async rst out_valid", 64'(out_valid), 64'd0);
    chk("async rst in_ready", 64'(in_ready), 64'd1);
    chk("async rst out_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    rc = 0;
    // No result must surface for the discarded pixel
    repeat (3) begin
      @(negedge clk);
      rc = rc + int'(out_valid);
    end
    chk("no ghost result", 64'(rc), 64'd0);
    run_pixel("post-rst c=1", 1'b0, FX_1, FX_0, FX_0, FX_0, 19'h04321, 2, 1'b1, 6, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mandel_iter_unit.md
# mandel_iter_unit

Parametrised single-pixel escape-time engine, the next-generation core for the fractal renderer. It accepts one complex coordinate per transaction over a valid/ready handshake and iterates z ← z² + c in signed fixed point of configurable width. It returns the iteration count, an escaped flag and a caller-supplied tag. It runs in Mandelbrot or Julia mode; upstream, a pixel dispatcher fans coordinates across N instances, and downstream, a tag-addressed frame-buffer writer collects results.

## Interface
- WIDTH, 27: total bits of every signed fixed-point operand.
- FRAC, 23: fraction bits. Requirement: WIDTH−FRAC ≥ 4.
- CNT_W, 10: width of the iteration count.
- MAX_ITER, 1000: iteration cap. Requirement: MAX_ITER < 2^CNT_W.
- TAG_W, 19: width of the opaque tag (pixel address).

- clk  in  1: the single clock.
- rst  in  1: asynchronous, active-low reset (low = reset).
- mode  in  1: 0 = Mandelbrot, 1 = Julia. Sampled at accept.
- jre, jim  in  WIDTH each: Julia constant. Sampled at accept.
- in_valid  in  1: a coordinate is offered.
- in_ready  out  1: the unit can accept.
- in_re, in_im  in  WIDTH each: pixel coordinate.
- in_tag  in  TAG_W: tag returned with the result.
- out_valid  out  1: a result is held.
- out_ready  in  1: downstream takes the result.
- out_count  out  CNT_W: iterations completed.
- out_escaped  out  1: 1 = |z| left radius 2 before the cap.
- out_tag  out  TAG_W: the accepted tag.

## Operation
- Every operand is signed Q(WIDTH−FRAC).FRAC.
- Product rule: take the full 2·WIDTH-bit signed product, then truncate to bits [WIDTH+FRAC−1 : FRAC].
- Overflow cannot occur, because |zre| and |zim| are both < 2 whenever multiplied.
- State machine: IDLE, MUL, UPD, OUT.
- IDLE: in_ready = 1. On in_valid, the unit latches the inputs as follows.
  - Mandelbrot: c = (in_re, in_im), z = 0.
  - Julia: z = (in_re, in_im), c = (jre, jim).
  - In both modes it latches the tag, sets count = 0 and moves to MUL.
- MUL:
  - If zre ≥ 2, zre ≤ −2, zim ≥ 2 or zim ≤ −2, then escaped = 1 and the next state is OUT.
  - Otherwise it registers sre = zre², sim = zim², x = zre·zim and moves to UPD.
- UPD: the sum sre + sim is formed in WIDTH+1 bits.
  - If sum ≥ 4: escaped = 1, next state OUT.
  - Else if count = MAX_ITER: escaped = 0, next state OUT.
  - Otherwise: zre ← sre − sim + cre, zim ← (x <<< 1) + cim, count ← count + 1, next state MUL.
- OUT: out_valid = 1, with out_count, out_escaped and out_tag stable. When out_ready is high the unit returns to IDLE.
- in_ready is combinational (state == IDLE). An input cannot be accepted in the same cycle that a result is consumed.
- mode, jre and jim may change freely while busy. Only the values sampled at accept matter.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, out_count 0, out_escaped 0, out_tag 0.
- Reset is asynchronous: assertion takes effect immediately. An in-flight pixel is discarded and no result is emitted.
- Accept happens at the clock edge where in_valid and in_ready are both high.
- Each iteration takes 2 cycles (MUL + UPD).
- A pixel that escapes in MUL with count = k has out_valid high from cycle 2k+2 after the accept edge.
- A pixel that escapes in UPD has out_valid high from cycle 2k+3.
- A capped pixel has out_valid high from cycle 2·MAX_ITER+3.
- OUT holds indefinitely while out_ready is low. Output fields do not change while out_valid is high.
- Minimum occupancy is one accept, one pixel compute and one OUT cycle. There is no overlap between pixels.

## Configuration
- MANDEL_BULB_SKIP_EN defined: in the IDLE→accept cycle, Mandelbrot mode only, the unit checks whether c lies in either conservative interior box.
  - Boxes (constants scaled by 2^FRAC at elaboration):
    - main: −0.5 < re < 0.0 and −0.4 < im < 0.4;
    - period-2: −1.17 < re < −0.83 and −0.17 < im < 0.17.
  - If c is in either box, the unit goes straight to OUT with out_count = MAX_ITER, escaped = 0, and out_valid from cycle 1 after accept.
- Undefined: no skip logic. Every pixel iterates. Results are identical except for latency.

## Test plan
- Mandelbrot, c = 2.0+0i → out_count 1, escaped 1, out_valid 4 cycles after accept.
- Mandelbrot, c = 1.0+0i → out_count 2, escaped 1; tag 0x1234 returned unchanged.
- Mandelbrot, c = −1.0+0i, macro off, MAX_ITER 16 → out_count 16, escaped 0, out_valid at cycle 35.
- Mandelbrot, c = −0.25+0i, macro on → out_count MAX_ITER, escaped 0, out_valid at cycle 1. Same input with the macro off → count MAX_ITER at cycle 2·MAX_ITER+3.
- Julia, jre = jim = 0, z0 = 3.0+0i → out_count 0, escaped 1, out_valid at cycle 2. With out_ready held low for 10 cycles, outputs stay stable and in_ready stays low.
- Drop rst mid-iteration → out_valid 0 and in_ready 1 immediately. After release, the next accepted pixel completes correctly.
